cmp_window_tracker: RTL and testbench

Streaming stage that sits directly upstream of the 2-bit GreaterThan comparator. It drives two comparator instances with the incoming sample and the running extremes, and consumes their `isGreater` results. It collects fixed-size windows of 2-bit samples over a valid/ready handshake. For each window it reports the maximum, the minimum, the index of the first maximum, and the number of strict new-maximum events.

---
 rtl/cmp_window_pkg.sv | 12 +
 rtl/GreaterThan.sv | 10 +
 rtl/cmp_window_tracker.sv | 168 ++++++++++++++++
 tb/tb_cmp_window_tracker.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cmp_window_pkg.sv
// Shared constants and FSM encoding for the window min/max tracker.
package cmp_window_pkg;

  localparam int unsigned SAMPLE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/GreaterThan.sv
// Unsigned 2-bit magnitude comparator: isGreater = (a > b).
module GreaterThan (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       isGreater
);

  assign isGreater = (a > b);

endmodule

// File: rtl/cmp_window_tracker.sv
// Collects fixed-size windows of 2-bit samples and reports max, min,
// index of first max and the count of strict new-maximum events.
module cmp_window_tracker
  import cmp_window_pkg::*;
#(
  parameter int unsigned WINDOW = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_max,
  output logic [SAMPLE_W-1:0] out_min,
  output logic [CNT_W-1:0]    out_index,
  output logic [CNT_W-1:0]    out_updates,
  output logic                busy
);

  localparam int unsigned LAST = WINDOW - 1;

  state_t              state_q, state_d;
  logic [SAMPLE_W-1:0] max_q, max_d;
  logic [SAMPLE_W-1:0] min_q, min_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    upd_q, upd_d;
  logic [CNT_W-1:0]    pos_q, pos_d;

  logic                in_ready_d, busy_d, out_valid_d;
  logic [SAMPLE_W-1:0] out_max_d, out_min_d;
  logic [CNT_W-1:0]    out_index_d, out_updates_d;

  logic accept_c;
  logic new_max_c;
  logic new_min_c;

  assign accept_c = in_valid & in_ready;

  // A: new sample above running max; B: running min above new sample
  GreaterThan u_gt_max (
    .a         (in_data),
    .b         (max_q),
    .isGreater (new_max_c)
  );

  GreaterThan u_gt_min (
    .a         (min_q),
    .b         (in_data),
    .isGreater (new_min_c)
  );

  // Next-state, accumulator and result logic
  always_comb begin
    state_d       = state_q;
    max_d         = max_q;
    min_d         = min_q;
    idx_d         = idx_q;
    upd_d         = upd_q;
    pos_d         = pos_q;
    out_valid_d   = out_valid;
    out_max_d     = out_max;
    out_min_d     = out_min;
    out_index_d   = out_index;
    out_updates_d = out_updates;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          max_d   = in_data;
          min_d   = in_data;
          idx_d   = '0;
          upd_d   = '0;
          pos_d   = CNT_W'(1);
          state_d = ST_ACCUM;
          if (WINDOW == 1) begin
            state_d       = ST_EMIT;
            out_valid_d   = 1'b1;
            out_max_d     = in_data;
            out_min_d     = in_data;
            out_index_d   = '0;
            out_updates_d = '0;
          end
        end
      end

      ST_ACCUM: begin
        if (accept_c) begin
          if (new_max_c) begin
            max_d = in_data;
            idx_d = pos_q;
            upd_d = upd_q + CNT_W'(1);
          end
          if (new_min_c) begin
            min_d = in_data;
          end
          pos_d = pos_q + CNT_W'(1);
          if (pos_q == CNT_W'(LAST)) begin
            state_d       = ST_EMIT;
            out_valid_d   = 1'b1;
            out_max_d     = max_d;
            out_min_d     = min_d;
            out_index_d   = idx_d;
            out_updates_d = upd_d;
          end
        end
      end

      ST_EMIT: begin
        if (out_ready) begin
          state_d       = ST_IDLE;
          max_d         = '0;
          min_d         = '0;
          idx_d         = '0;
          upd_d         = '0;
          pos_d         = '0;
          out_valid_d   = 1'b0;
          out_max_d     = '0;
          out_min_d     = '0;
          out_index_d   = '0;
          out_updates_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d != ST_EMIT);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      max_q       <= '0;
      min_q       <= '0;
      idx_q       <= '0;
      upd_q       <= '0;
      pos_q       <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_max     <= '0;
      out_min     <= '0;
      out_index   <= '0;
      out_updates <= '0;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      min_q       <= min_d;
      idx_q       <= idx_d;
      upd_q       <= upd_d;
      pos_q       <= pos_d;
      in_ready    <= in_ready_d;
      busy        <= busy_d;
      out_valid   <= out_valid_d;
      out_max     <= out_max_d;
      out_min     <= out_min_d;
      out_index   <= out_index_d;
      out_updates <= out_updates_d;
    end
  end

endmodule

// File: tb/tb_cmp_window_tracker.sv
// Directed bench for cmp_window_tracker with WINDOW=4, hand-computed results.
module tb_cmp_window_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_max;
  logic [1:0] out_min;
  logic [3:0] out_index;
  logic [3:0] out_updates;
  logic       busy;

  int checks = 0;
  int errors = 0;

  cmp_window_tracker #(.WINDOW(4), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_max     (out_max),
    .out_min     (out_min),
    .out_index   (out_index),
    .out_updates (out_updates),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until accepted (bounded)
  task automatic send(input logic [1:0] d);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 20 && !done; n++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 8'(0), 8'(1));
  endtask

  task automatic gap();
    in_valid = 1'b0;
    in_data  = 2'd3;
    tick();
  endtask

  task automatic expect_result(input string tag, input logic [1:0] mx, input logic [1:0] mn,
                               input logic [3:0] ix, input logic [3:0] up);
    check({tag, "_valid"},   8'(out_valid), 8'(1));
    check({tag, "_max"},     8'(out_max), 8'(mx));
    check({tag, "_min"},     8'(out_min), 8'(mn));
    check({tag, "_index"},   8'(out_index), 8'(ix));
    check({tag, "_updates"}, 8'(out_updates), 8'(up));
    check({tag, "_inready"}, 8'(in_ready), 8'(0));
    tick();
    check({tag, "_valid_drop"},   8'(out_valid), 8'(0));
    check({tag, "_max_clear"},    8'(out_max), 8'(0));
    check({tag, "_ready_back"},   8'(in_ready), 8'(1));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 2'd0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready",  8'(in_ready), 8'(0));
    check("rst_out_valid", 8'(out_valid), 8'(0));
    check("rst_busy",      8'(busy), 8'(0));
    check("rst_max",       8'(out_max), 8'(0));
    check("rst_min",       8'(out_min), 8'(0));
    check("rst_index",     8'(out_index), 8'(0));
    check("rst_updates",   8'(out_updates), 8'(0));
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", 8'(in_ready), 8'(1));
    check("post_rst_busy",     8'(busy), 8'(0));

    // 1,3,0,2
    send(2'd1);
    check("w1_busy", 8'(busy), 8'(1));
    send(2'd3);
    send(2'd0);
    check("w1_no_early", 8'(out_valid), 8'(0));
    send(2'd2);
    expect_result("w1", 2'd3, 2'd0, 4'd1, 4'd1);
    check("w1_idle_busy", 8'(busy), 8'(0));

    // ties never update
    send(2'd2); send(2'd2); send(2'd2); send(2'd2);
    expect_result("ties", 2'd2, 2'd2, 4'd0, 4'd0);

    // ascending
    send(2'd0); send(2'd1); send(2'd2); send(2'd3);
    expect_result("asc", 2'd3, 2'd0, 4'd3, 4'd3);

    // gaps: 0,-,-,3,-,1,2
    send(2'd0); gap(); gap();
    check("gap_busy_held", 8'(busy), 8'(1));
    send(2'd3); gap();
    send(2'd1);
    check("gap_no_early", 8'(out_valid), 8'(0));
    send(2'd2);
    expect_result("gap", 2'd3, 2'd0, 4'd1, 4'd1);

    // backpressure: 3,1,2,0 held for 5 cycles
    out_ready = 1'b0;
    send(2'd3); send(2'd1); send(2'd2); send(2'd0);
    in_valid = 1'b1;
    in_data  = 2'd1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",    8'(out_valid), 8'(1));
      check("bp_in_ready", 8'(in_ready), 8'(0));
      check("bp_max",      8'(out_max), 8'(3));
      check("bp_min",      8'(out_min), 8'(0));
      check("bp_index",    8'(out_index), 8'(0));
      check("bp_updates",  8'(out_updates), 8'(0));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_released", 8'(out_valid), 8'(0));
    check("bp_ready",    8'(in_ready), 8'(1));
    check("bp_busy",     8'(busy), 8'(0));
    // next window 1,0,3,3 starts immediately
    send(2'd1); send(2'd0); send(2'd3); send(2'd3);
    expect_result("after_bp", 2'd3, 2'd0, 4'd2, 4'd1);

    // reset mid-window discards partial result
    send(2'd3); send(2'd3);
    reset = 1'b1;
    tick();
    check("abort_valid", 8'(out_valid), 8'(0));
    check("abort_busy",  8'(busy), 8'(0));
    check("abort_ready", 8'(in_ready), 8'(0));
    reset = 1'b0;
    tick();
    check("abort_ready_back", 8'(in_ready), 8'(1));
    send(2'd0); send(2'd1); send(2'd1);
    check("abort_no_early", 8'(out_valid), 8'(0));
    send(2'd0);
    expect_result("abort", 2'd1, 2'd0, 4'd1, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
